// File: rtl/scrambler_pkg.sv
// Shared types and helpers for the scrambler control block.
package scrambler_pkg;

  localparam int unsigned SEED_W = 7;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPass,
    StDrop
  } state_e;

  // Seed advance: hold when incr is low, otherwise +1 with 127 wrapping to 1 so 0 never appears.
  function automatic logic [SEED_W-1:0] next_seed(input logic [SEED_W-1:0] cur,
                                                  input logic              incr);
    if (!incr) begin
      return cur;
    end
    if (cur == {SEED_W{1'b1}}) begin
      return SEED_W'(1);
    end
    return cur + SEED_W'(1);
  endfunction

endpackage

// File: rtl/scrambler_seed_gen.sv
// Seed register for the scrambler: config writes (IDLE only, nonzero only) and per-frame advance.
module scrambler_seed_gen
  import scrambler_pkg::*;
#(
  parameter logic [SEED_W-1:0] SEED = 7'b1011101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idle,
  input  logic              advance,
  input  logic              cfg_incr,
  input  logic              cfg_seed_wr,
  input  logic [SEED_W-1:0] cfg_seed,
  output logic [SEED_W-1:0] seed,
  output logic              cfg_err
);

  logic [SEED_W-1:0] seed_q, seed_d;
  logic              cfg_err_q, cfg_err_d;
  logic              wr_ok;

  // Writes and advances are mutually exclusive: writes land only in IDLE, advances only in PASS.
  always_comb begin
    wr_ok     = cfg_seed_wr && idle && (cfg_seed != '0);
    cfg_err_d = cfg_seed_wr && !wr_ok;
    seed_d    = seed_q;
    if (wr_ok) begin
      seed_d = cfg_seed;
    end else if (advance) begin
      seed_d = next_seed(seed_q, cfg_incr);
    end
  end

  // Seed and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q    <= SEED;
      cfg_err_q <= 1'b0;
    end else begin
      seed_q    <= seed_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign seed    = seed_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: rtl/scrambler_ctrl.sv
// Frame controller in front of a scrambler: loads a seed per frame, passes the stream through
// with zero latency and truncates frames longer than MAX_LEN beats.
// Optional statistics counters are built when SCRAMBLER_CTRL_STATS_EN is defined.
module scrambler_ctrl
  import scrambler_pkg::*;
#(
  parameter int unsigned       WIDTH   = 24,
  parameter logic [SEED_W-1:0] SEED    = 7'b1011101,
  parameter int unsigned       MAX_LEN = 256
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [WIDTH-1:0]  s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [WIDTH-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              seed_load,
  output logic [SEED_W-1:0] seed,
  input  logic              cfg_seed_wr,
  input  logic [SEED_W-1:0] cfg_seed,
  input  logic              cfg_incr,
  output logic              cfg_err,
  output logic [15:0]       frame_count,
  output logic              overlong,
  output logic [15:0]       overlong_count
);

  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

  state_e           state_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             seed_load_q;
  logic             overlong_q;
  logic             accept;
  logic             last_beat;
  logic             trunc;
  logic             advance;

  // Beat bookkeeping: last_beat means the beat now on the bus would be number MAX_LEN.
  always_comb begin
    last_beat = (beat_cnt_q == CNT_W'(MAX_LEN - 1));
    accept    = (state_q == StPass) && s_axis_tvalid && m_axis_tready;
    trunc     = accept && !s_axis_tlast && last_beat;
    advance   = accept && (s_axis_tlast || last_beat);
  end

  // Handshake muxing: pass-through in PASS, sink in DROP, closed otherwise.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = s_axis_tdata;
    case (state_q)
      StPass: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast | last_beat;
      end
      StDrop: s_axis_tready = 1'b1;
      default: ;
    endcase
  end

  // Frame FSM with registered seed_load and overlong pulses.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      seed_load_q <= 1'b0;
      overlong_q  <= 1'b0;
    end else begin
      seed_load_q <= 1'b0;
      overlong_q  <= trunc;
      case (state_q)
        StIdle: begin
          if (s_axis_tvalid) begin
            state_q     <= StLoad;
            seed_load_q <= 1'b1;
            beat_cnt_q  <= '0;
          end
        end
        StLoad: state_q <= StPass;
        StPass: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            if (s_axis_tlast) begin
              state_q <= StIdle;
            end else if (last_beat) begin
              state_q <= StDrop;
            end
          end
        end
        StDrop: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign seed_load = seed_load_q;
  assign overlong  = overlong_q;

  scrambler_seed_gen #(
    .SEED(SEED)
  ) u_seed_gen (
    .clk        (aclk),
    .rst_n      (aresetn),
    .idle       (state_q == StIdle),
    .advance    (advance),
    .cfg_incr   (cfg_incr),
    .cfg_seed_wr(cfg_seed_wr),
    .cfg_seed   (cfg_seed),
    .seed       (seed),
    .cfg_err    (cfg_err)
  );

`ifdef SCRAMBLER_CTRL_STATS_EN
  logic [15:0] frame_count_q;
  logic [15:0] overlong_count_q;

  // Completed and truncated frame counters, wrapping at 2^16.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_count_q    <= '0;
      overlong_count_q <= '0;
    end else begin
      if (advance) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
      if (trunc) begin
        overlong_count_q <= overlong_count_q + 16'd1;
      end
    end
  end

  assign frame_count    = frame_count_q;
  assign overlong_count = overlong_count_q;
`else
  assign frame_count    = '0;
  assign overlong_count = '0;
`endif

endmodule

// File: tb/tb_scrambler_ctrl.sv
// Directed bench for scrambler_ctrl: a default instance plus a MAX_LEN=4 instance for truncation.
module tb_scrambler_ctrl;

  localparam int         W        = 24;
  localparam logic [6:0] SEED_DEF = 7'b1011101;
`ifdef SCRAMBLER_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [W-1:0] s_tdata = '0;
  logic         s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
  logic         cfg_seed_wr = 1'b0, cfg_incr = 1'b0, use4 = 1'b0;
  logic [6:0]   cfg_seed = '0;

  logic         s_tready0, m_tvalid0, m_tlast0, seed_load0, cfg_err0, overlong0;
  logic [W-1:0] m_tdata0;
  logic [6:0]   seed0;
  logic [15:0]  frame_count0, overlong_count0;
  logic         s_tready4, m_tvalid4, m_tlast4, seed_load4, cfg_err4, overlong4;
  logic [W-1:0] m_tdata4;
  logic [6:0]   seed4;
  logic [15:0]  frame_count4, overlong_count4;

  logic         sr, mv, ml, sl;
  logic [W-1:0] md;
  logic [6:0]   sd;

  assign sr = use4 ? s_tready4  : s_tready0;
  assign mv = use4 ? m_tvalid4  : m_tvalid0;
  assign ml = use4 ? m_tlast4   : m_tlast0;
  assign md = use4 ? m_tdata4   : m_tdata0;
  assign sl = use4 ? seed_load4 : seed_load0;
  assign sd = use4 ? seed4      : seed0;

  int n_cmp = 0;
  int n_fail = 0;
  logic [W:0] out_q[$];
  logic [6:0] seed_q[$];
  int cfg_err_pulses = 0;
  int ol4_pulses = 0;
  int mirror_err = 0;

  always #5 aclk = ~aclk;

  scrambler_ctrl dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid & ~use4), .s_axis_tready(s_tready0),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast0),
    .seed_load(seed_load0), .seed(seed0), .cfg_seed_wr(cfg_seed_wr), .cfg_seed(cfg_seed),
    .cfg_incr(cfg_incr), .cfg_err(cfg_err0), .frame_count(frame_count0),
    .overlong(overlong0), .overlong_count(overlong_count0)
  );

  scrambler_ctrl #(.MAX_LEN(4)) dut4 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid & use4), .s_axis_tready(s_tready4),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata4), .m_axis_tvalid(m_tvalid4), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast4),
    .seed_load(seed_load4), .seed(seed4), .cfg_seed_wr(cfg_seed_wr), .cfg_seed(cfg_seed),
    .cfg_incr(cfg_incr), .cfg_err(cfg_err4), .frame_count(frame_count4),
    .overlong(overlong4), .overlong_count(overlong_count4)
  );

  // Monitor samples 1 time unit before each rising edge; inputs change on falling edges.
  always begin
    @(negedge aclk);
    #4;
    if (mv && m_tready) out_q.push_back({ml, md});
    if (sl) seed_q.push_back(sd);
    if (cfg_err0) cfg_err_pulses++;
    if (overlong4) ol4_pulses++;
    if (mv && (sr !== m_tready)) mirror_err++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Sends n beats (data base+i, tlast on the final one); entered and left on a falling edge.
  task automatic send_frame(input int n, input logic [W-1:0] base, input bit tog, output bit to);
    int  guard;
    bit  done;
    to = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = base + W'(i);
      s_tlast  = (i == n - 1);
      done     = 1'b0;
      guard    = 0;
      while (!done) begin
        if (tog) m_tready = ~m_tready;
        #4;
        if (sr) done = 1'b1;
        @(negedge aclk);
        guard++;
        if (!done && guard > 50) begin
          to   = 1'b1;
          done = 1'b1;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge aclk);
    #1;
    n_cmp++; if (seed0 !== SEED_DEF) begin n_fail++; $display("FAIL reset_seed: got %h want %h", seed0, SEED_DEF); end
    n_cmp++; if ({seed_load0, cfg_err0, overlong0, m_tvalid0, s_tready0} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {seed_load0, cfg_err0, overlong0, m_tvalid0, s_tready0});
    end
    n_cmp++; if ({frame_count0, overlong_count0} !== 32'h0) begin
      n_fail++; $display("FAIL reset_counts: got %h want 0", {frame_count0, overlong_count0});
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_basic_frame();
    bit to;
    logic [W:0] got, exp;
    out_q.delete(); seed_q.delete();
    m_tready = 1'b1; cfg_incr = 1'b0;
    s_tvalid = 1'b1; #1;
    n_cmp++; if (s_tready0 !== 1'b0 || m_tvalid0 !== 1'b0) begin
      n_fail++; $display("FAIL idle_handshake: got %b%b want 00", s_tready0, m_tvalid0);
    end
    send_frame(3, 24'hA5A5A0, 1'b0, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b want 0", to); end
    n_cmp++; if (seed_q.size() != 1) begin n_fail++; $display("FAIL basic_load_count: got %0d want 1", seed_q.size()); end
    n_cmp++; if (seed_q.size() == 0 || seed_q[0] !== SEED_DEF) begin
      n_fail++; $display("FAIL basic_load_seed: got %h want %h", (seed_q.size() > 0) ? seed_q[0] : 7'bx, SEED_DEF);
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < out_q.size()) ? out_q[i] : {(W+1){1'bx}};
      exp = {(i == 2), 24'hA5A5A0 + W'(i)};
      n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL basic_beat%0d: got %h want %h", i, got, exp); end
    end
    n_cmp++; if (frame_count0 !== (STATS ? 16'd1 : 16'd0)) begin
      n_fail++; $display("FAIL basic_frame_count: got %0d want %0d", frame_count0, STATS ? 1 : 0);
    end
  endtask

  task automatic test_seed_incr();
    bit to, any_to;
    logic [6:0] exp_seeds [4];
    exp_seeds[0] = 7'd126; exp_seeds[1] = 7'd127; exp_seeds[2] = 7'd1; exp_seeds[3] = 7'd2;
    out_q.delete(); seed_q.delete();
    cfg_incr = 1'b1; cfg_seed = 7'd126; cfg_seed_wr = 1'b1;
    @(negedge aclk);
    cfg_seed_wr = 1'b0; #1;
    n_cmp++; if (seed0 !== 7'd126) begin n_fail++; $display("FAIL incr_write: got %0d want 126", seed0); end
    any_to = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_frame(1, 24'h000010 + W'(k), 1'b0, to);
      any_to |= to;
    end
    n_cmp++; if (any_to !== 1'b0) begin n_fail++; $display("FAIL incr_timeout: got 1 want 0"); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (k >= seed_q.size() || seed_q[k] !== exp_seeds[k]) begin
        n_fail++; $display("FAIL incr_seed%0d: got %0d want %0d", k, (k < seed_q.size()) ? seed_q[k] : 7'bx, exp_seeds[k]);
      end
    end
    n_cmp++; if (seed0 !== 7'd3) begin n_fail++; $display("FAIL incr_final_seed: got %0d want 3", seed0); end
    n_cmp++; if (frame_count0 !== (STATS ? 16'd5 : 16'd0)) begin
      n_fail++; $display("FAIL incr_frame_count: got %0d want %0d", frame_count0, STATS ? 5 : 0);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [W:0] got, exp;
    out_q.delete(); seed_q.delete();
    cfg_incr = 1'b0; m_tready = 1'b1; mirror_err = 0;
    send_frame(5, 24'h700000, 1'b1, to);
    m_tready = 1'b1;
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got %b want 0", to); end
    n_cmp++; if (out_q.size() != 5) begin n_fail++; $display("FAIL b2b_beat_count: got %0d want 5", out_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < out_q.size()) ? out_q[i] : {(W+1){1'bx}};
      exp = {(i == 4), 24'h700000 + W'(i)};
      n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL b2b_beat%0d: got %h want %h", i, got, exp); end
    end
    n_cmp++; if (mirror_err != 0) begin n_fail++; $display("FAIL b2b_tready_mirror: got %0d errors want 0", mirror_err); end
    n_cmp++; if (seed0 !== 7'd3) begin n_fail++; $display("FAIL b2b_fixed_seed: got %0d want 3", seed0); end
  endtask

  task automatic test_cfg_err();
    bit to;
    out_q.delete(); seed_q.delete();
    cfg_err_pulses = 0;
    cfg_seed = 7'd0; cfg_seed_wr = 1'b1;
    @(negedge aclk);
    cfg_seed_wr = 1'b0; #1;
    n_cmp++; if (seed0 !== 7'd3) begin n_fail++; $display("FAIL cfg_zero_seed: got %0d want 3", seed0); end
    @(negedge aclk);
    fork
      send_frame(3, 24'h500000, 1'b0, to);
      begin
        @(negedge aclk); cfg_seed = 7'd55; cfg_seed_wr = 1'b1;
        @(negedge aclk); cfg_seed_wr = 1'b0;
        @(negedge aclk); cfg_seed_wr = 1'b1;
        @(negedge aclk); cfg_seed_wr = 1'b0;
      end
    join
    repeat (2) @(negedge aclk);
    n_cmp++; if (cfg_err_pulses != 3) begin n_fail++; $display("FAIL cfg_err_pulses: got %0d want 3", cfg_err_pulses); end
    n_cmp++; if (seed0 !== 7'd3) begin n_fail++; $display("FAIL cfg_midframe_seed: got %0d want 3", seed0); end
    n_cmp++; if (seed_q.size() == 0 || seed_q[0] !== 7'd3) begin n_fail++; $display("FAIL cfg_frame_seed: got other want 3"); end
    n_cmp++; if (out_q.size() != 3) begin n_fail++; $display("FAIL cfg_frame_beats: got %0d want 3", out_q.size()); end
  endtask

  task automatic test_overlong();
    bit to1, to2;
    logic [W:0] got;
    logic [W:0] exp [5];
    exp[0] = {1'b0, 24'h000100}; exp[1] = {1'b0, 24'h000101}; exp[2] = {1'b0, 24'h000102};
    exp[3] = {1'b1, 24'h000103}; exp[4] = {1'b1, 24'h000200};
    out_q.delete(); seed_q.delete();
    use4 = 1'b1; m_tready = 1'b1; ol4_pulses = 0;
    send_frame(6, 24'h000100, 1'b0, to1);
    repeat (2) @(negedge aclk);
    send_frame(1, 24'h000200, 1'b0, to2);
    repeat (2) @(negedge aclk);
    n_cmp++; if ({to1, to2} !== 2'b00) begin n_fail++; $display("FAIL ovl_timeout: got %b want 00", {to1, to2}); end
    n_cmp++; if (out_q.size() != 5) begin n_fail++; $display("FAIL ovl_beat_count: got %0d want 5", out_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < out_q.size()) ? out_q[i] : {(W+1){1'bx}};
      n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL ovl_beat%0d: got %h want %h", i, got, exp[i]); end
    end
    n_cmp++; if (ol4_pulses != 1) begin n_fail++; $display("FAIL ovl_pulse: got %0d want 1", ol4_pulses); end
    n_cmp++; if (overlong_count4 !== (STATS ? 16'd1 : 16'd0)) begin
      n_fail++; $display("FAIL ovl_count: got %0d want %0d", overlong_count4, STATS ? 1 : 0);
    end
    n_cmp++; if (frame_count4 !== (STATS ? 16'd2 : 16'd0)) begin
      n_fail++; $display("FAIL ovl_frame_count: got %0d want %0d", frame_count4, STATS ? 2 : 0);
    end
    n_cmp++; if (overlong_count0 !== 16'd0) begin n_fail++; $display("FAIL ovl_main_count: got %0d want 0", overlong_count0); end
    use4 = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit to;
    cfg_incr = 1'b0; cfg_seed = 7'd20; cfg_seed_wr = 1'b1;
    @(negedge aclk);
    cfg_seed_wr = 1'b0;
    s_tvalid = 1'b1; s_tdata = 24'h300000; s_tlast = 1'b0;
    repeat (3) @(negedge aclk);
    s_tdata = 24'h300001; #1;
    n_cmp++; if (m_tvalid0 !== 1'b1 || seed0 !== 7'd20) begin
      n_fail++; $display("FAIL rst_pre_pass: got valid=%b seed=%0d want valid=1 seed=20", m_tvalid0, seed0);
    end
    aresetn = 1'b0; #1;
    n_cmp++; if ({m_tvalid0, s_tready0, m_tlast0, seed_load0, cfg_err0, overlong0} !== 6'b0) begin
      n_fail++; $display("FAIL rst_mid_flags: got %b want 000000", {m_tvalid0, s_tready0, m_tlast0, seed_load0, cfg_err0, overlong0});
    end
    n_cmp++; if (seed0 !== SEED_DEF) begin n_fail++; $display("FAIL rst_mid_seed: got %h want %h", seed0, SEED_DEF); end
    n_cmp++; if ({frame_count0, overlong_count0} !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_counts: got %h want 0", {frame_count0, overlong_count0});
    end
    @(negedge aclk);
    aresetn = 1'b1; s_tvalid = 1'b0;
    @(negedge aclk);
    out_q.delete(); seed_q.delete();
    send_frame(2, 24'h400000, 1'b0, to);
    n_cmp++; if (to !== 1'b0 || out_q.size() != 2) begin
      n_fail++; $display("FAIL rst_next_frame: got timeout=%b beats=%0d want 0/2", to, out_q.size());
    end
    n_cmp++; if (seed_q.size() != 1 || seed_q[0] !== SEED_DEF) begin
      n_fail++; $display("FAIL rst_next_seed: got %h want %h", (seed_q.size() > 0) ? seed_q[0] : 7'bx, SEED_DEF);
    end
    n_cmp++; if (frame_count0 !== (STATS ? 16'd1 : 16'd0)) begin
      n_fail++; $display("FAIL rst_next_count: got %0d want %0d", frame_count0, STATS ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_seed_incr();
    test_back_to_back();
    test_cfg_err();
    test_overlong();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/scrambler_ctrl.md
SCRAMBLER_CTRL -- requirements
Module: scrambler_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24: stream data width in bits.
REQ-002 The block SHALL have parameter SEED, default 7'b1011101: seed value after reset.
REQ-003 The block SHALL have parameter MAX_LEN, default 256: maximum number of beats in one frame.
REQ-004 Port aclk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port aresetn, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 Ports s_axis_tdata, s_axis_tvalid, s_axis_tready and s_axis_tlast SHALL form the AXI-Stream input: WIDTH/1/1/1 bits; in/in/out/in.
REQ-007 Ports m_axis_tdata, m_axis_tvalid, m_axis_tready and m_axis_tlast SHALL form the AXI-Stream output to the scrambler: WIDTH/1/1/1 bits; out/out/in/out.
REQ-008 Port seed_load, output, 1 bit: one-cycle pulse that loads seed into the scrambler.
REQ-009 Port seed, output, 7 bits: the seed for the next frame.
REQ-010 Port cfg_seed_wr, input, 1 bit: write strobe for cfg_seed.
REQ-011 Port cfg_seed, input, 7 bits: seed value to write.
REQ-012 Port cfg_incr, input, 1 bit: 0 = keep the seed fixed, 1 = increment the seed after each frame.
REQ-013 Port cfg_err, output, 1 bit: pulses when a seed write is rejected.
REQ-014 Port frame_count, output, 16 bits: number of completed frames.
REQ-015 Port overlong, output, 1 bit: pulses when a frame is truncated.
REQ-016 Port overlong_count, output, 16 bits: number of truncated frames.

Function
REQ-017 The block SHALL use an FSM with states IDLE, LOAD, PASS and DROP.
REQ-018 In IDLE, s_axis_tready and m_axis_tvalid SHALL be 0; s_axis_tvalid=1 SHALL move the FSM to LOAD.
REQ-019 In LOAD, seed_load SHALL be 1 for exactly one cycle, no data SHALL transfer, and the next state SHALL be PASS.
REQ-020 In PASS, the path SHALL be combinational with zero latency: m_tdata=s_tdata, m_tvalid=s_tvalid, m_tlast=s_tlast, s_tready=m_tready.
REQ-021 In PASS, a beat count SHALL increment on each accepted beat (m_tvalid & m_tready).
REQ-022 An accepted beat with s_tlast=1 SHALL return the FSM to IDLE, advance the seed (REQ-025) and increment frame_count.
REQ-023 If an accepted beat is beat number MAX_LEN without tlast:
  - m_tlast SHALL be forced to 1 on that beat;
  - overlong SHALL pulse and overlong_count SHALL increment;
  - the seed SHALL advance and frame_count SHALL increment;
  - the next state SHALL be DROP.
REQ-024 In DROP, s_tready SHALL be 1 and m_tvalid SHALL be 0; input beats SHALL be discarded until an accepted tlast, then the FSM SHALL return to IDLE.
REQ-025 Seed advance SHALL be: cfg_incr=0 keeps the seed unchanged; cfg_incr=1 sets seed+1, wrapping 127 to 1 (0 is never produced).
REQ-026 cfg_seed_wr in IDLE SHALL load cfg_seed on the next edge; cfg_seed=0 SHALL be rejected with a cfg_err pulse.
REQ-027 cfg_seed_wr in LOAD, PASS or DROP SHALL be ignored and SHALL pulse cfg_err.
REQ-028 A seed write and a seed advance in the same cycle cannot occur, because writes are accepted only in IDLE.
REQ-029 frame_count and overlong_count SHALL wrap modulo 2^16.
REQ-030 The beat counter SHALL be $clog2(MAX_LEN+1) bits wide and SHALL clear on entry to LOAD.

Reset
REQ-031 On aresetn=0, asynchronously: FSM=IDLE, seed=SEED, counters=0, and seed_load, cfg_err, overlong, m_tvalid and s_tready=0.
REQ-032 Reset during PASS SHALL abandon the frame with no truncation tlast emitted; the first frame after reset SHALL use SEED.

Configuration
REQ-033 With SCRAMBLER_CTRL_STATS_EN defined, frame_count, overlong_count and their registers SHALL be implemented.
REQ-034 Without SCRAMBLER_CTRL_STATS_EN, frame_count and overlong_count SHALL be tied to 0 and no counter flops SHALL exist.
REQ-035 overlong SHALL be present in both builds.

Structure
REQ-036 Package scrambler_pkg SHALL hold:
  - SEED_W=7;
  - the FSM state enum;
  - a next_seed function implementing the REQ-025 wrap rule.
REQ-037 Sub-module scrambler_seed_gen SHALL hold the seed register, write/reject logic and advance; the FSM and handshake SHALL stay in scrambler_ctrl.

Verification
REQ-038 Reset, 3-beat frame with tlast on beat 3, m_tready=1 -> one seed_load pulse with seed=7'b1011101; 3 beats pass unchanged; frame_count=1.
REQ-039 cfg_incr=1, four 1-beat frames starting from cfg_seed=126 -> seed_load values 126, 127, 1, 2.
REQ-040 MAX_LEN=4, 6-beat frame -> beat 4 output with m_tlast=1; beats 5 and 6 absorbed with m_tvalid=0; overlong pulse; overlong_count=1.
REQ-041 m_tready toggled every cycle during a 5-beat frame -> no beat lost or duplicated; s_tready mirrors m_tready in PASS.
REQ-042 cfg_seed_wr with cfg_seed=0 in IDLE, and any cfg_seed_wr mid-frame -> cfg_err pulses; seed unchanged.
REQ-043 aresetn deasserted for one cycle at beat 2 of a frame -> outputs at reset values; next frame seed=SEED; build without SCRAMBLER_CTRL_STATS_EN -> counters read 0.
